// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake and IF/ID write/flush controls.
// Define FETCH_PERF_EN to add the perf_fetched / perf_bubbles counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [63:0] ifid_data,
  output logic        IFID_write,
  output logic        IFflush,
  output logic [31:0] pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] hold_instr;
  logic [31:0] drain_addr;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (redirect)      state_nxt = imem_ack ? FETCH : DRAIN;
        else if (imem_ack) state_nxt = stall_in ? HOLD : FETCH;
      end
      HOLD:  if (redirect || !stall_in) state_nxt = FETCH;
      DRAIN: if (imem_ack) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (state == FETCH) || (state == DRAIN);
    // DRAIN keeps presenting the pre-redirect address; pc already holds the new target
    imem_addr  = (state == DRAIN) ? drain_addr : pc;
    IFflush    = redirect && (state != IDLE);
    IFID_write = !redirect && !stall_in &&
                 (((state == FETCH) && imem_ack) || (state == HOLD));
    ifid_data  = '0;
    if (state != IDLE)
      ifid_data = {pc_plus4, (state == HOLD) ? hold_instr : imem_rdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      hold_instr <= '0;
      drain_addr <= '0;
    end else if (state != IDLE) begin
      if (redirect)        pc <= redirect_pc;
      else if (IFID_write) pc <= pc_plus4;
      if ((state == FETCH) && imem_ack && stall_in && !redirect)
        hold_instr <= imem_rdata;
      if ((state == FETCH) && redirect && !imem_ack)
        drain_addr <= pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (IFID_write && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 32'd1;
      if ((state != IDLE) && !IFID_write && (perf_bubbles != '1))
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction-fetch stage; writes the IF/ID pipeline register.
- Holds the PC and runs a req/ack handshake to instruction memory.
- Drives the 64-bit IF/ID bundle {pc+4, instr} and the register's IFID_write / IFflush controls.
- Applies load-use stalls and branch/jump redirects resolved in ID.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held until acked.
- imem_addr  out  32  fetch address, equal to the current pc.
- imem_ack  in  1  response valid. Only meaningful while imem_req=1.
- imem_rdata  in  32  instruction word. Valid with imem_ack.
- stall_in  in  1  load-use stall from the hazard unit.
- redirect  in  1  branch/jump taken in ID.
- redirect_pc  in  32  target address. Valid with redirect.
- ifid_data  out  64  [63:32]=pc+4, [31:0]=instruction.
- IFID_write  out  1  1 = IF/ID loads ifid_data; 0 = IF/ID loads a bubble.
- IFflush  out  1  clears the instruction field of IF/ID.
- pc  out  32  current fetch PC.

## Operation
States: IDLE, FETCH, HOLD, DRAIN.

- **IDLE** (reset state): imem_req=0. Always moves to FETCH on the next cycle.
- **FETCH**: imem_req=1, imem_addr=pc.
  - ack, stall_in=0, redirect=0: IFID_write=1, ifid_data={pc+4, imem_rdata}, pc<=pc+4. Stay in FETCH; the next request issues the following cycle.
  - ack, stall_in=1, redirect=0: capture imem_rdata in hold_instr, go to HOLD. pc unchanged.
  - no ack: stay in FETCH with imem_addr stable.
- **HOLD**: imem_req=0, ifid_data={pc+4, hold_instr}.
  - When stall_in=0: IFID_write=1, pc<=pc+4, go to FETCH.
- **DRAIN**: imem_req=1, imem_addr=the old (pre-redirect) address. The request cannot be withdrawn.
  - On ack: discard data, go to FETCH (already at the new pc).
- **Redirect** (any state except IDLE) has priority over stall and ack:
  - IFflush=1, IFID_write=0, pc<=redirect_pc.
  - Next state is DRAIN if in FETCH without ack this cycle, or already in DRAIN without ack this cycle.
  - Otherwise next state is FETCH.
  - A redirect in DRAIN retargets pc but keeps the old imem_addr until ack.
- Arithmetic: pc+4 is modulo 2^32 (0xFFFF_FFFC wraps to 0). pc[1:0] is not checked.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, IFID_write=0, IFflush=0, ifid_data=0, hold_instr=0.
- Reset assertion mid-transaction abandons any outstanding request immediately. The memory must tolerate the request being dropped.
- IFID_write, IFflush and ifid_data are combinational from state, hold_instr, pc and the current inputs. IF/ID captures them on the same edge.
- Zero-wait memory (ack in the request cycle) gives one instruction per cycle.
- Each cycle FETCH waits adds one bubble (IFID_write=0).
- stall_in with no pending ack produces IFID_write=0 only.
- IFflush=1 for exactly the cycles in which redirect=1 and state≠IDLE. IFflush is 0 in IDLE.
- Redirect and ack in the same FETCH cycle: data is discarded and the next request targets redirect_pc.

## Configuration
- FETCH_PERF_EN defined:
  - Adds output perf_fetched[31:0], counting cycles with IFID_write=1.
  - Adds output perf_bubbles[31:0], counting cycles with state≠IDLE and IFID_write=0.
  - Both counters saturate at 0xFFFF_FFFF and reset to 0.
- FETCH_PERF_EN not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory returning addr^0xA5A5_0000 -> IDLE for 1 cycle. Then IFID_write=1 each cycle with ifid_data={0x104, 0xA5A5_0100}, {0x108, 0xA5A5_0104}, …
- Ack delayed 3 cycles at pc=0x200 -> imem_addr held at 0x200. IFID_write=0 for 3 cycles, then 1 with [63:32]=0x204.
- stall_in=1 for 2 cycles while the ack for 0x300 arrives -> HOLD, IFID_write=0 for 2 cycles. Then IFID_write=1 with the held word, and the next request goes to 0x304.
- Redirect to 0x800 while a request for 0x40 is outstanding -> IFflush=1 for 1 cycle, DRAIN keeps imem_addr=0x40 until ack, data discarded. The next request is 0x800.
- pc=0xFFFF_FFFC delivered -> ifid_data[63:32]=0. The next imem_addr is 0.
- Reset asserted while in HOLD -> imem_req=0, pc=RESET_PC, IFID_write=0 immediately. With FETCH_PERF_EN, both counters read 0.
